// File: rtl/pwm_pkg.sv
// ============================================================================
// Module      : pwm_pkg
// Description : Shared definitions for the PWM generator / capture pair.
//               Holds the measurement FSM state encoding and the default
//               counter width, synchroniser depth and timeout.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam int unsigned c_WIDTH       = 16;
  localparam int unsigned c_SYNC_STAGES = 2;
  localparam int unsigned c_TIMEOUT     = 65535;

  // ARM : waiting for the first rising edge of a period
  // HIGH: between a rise and the following fall
  // LOW : between a fall and the closing rise
  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

endpackage

`default_nettype wire

// File: rtl/pwm_sync_edge.sv
// ============================================================================
// Module      : pwm_sync_edge
// Description : Multi-flop synchroniser for an asynchronous level plus a
//               prev flop for rise/fall detection. All flops reset to 1, so
//               a high input at reset release produces no edge and a low
//               input produces only a falling edge.
// Ports       : clk      - system clock
//               reset    - synchronous active-high reset
//               i_async  - asynchronous input level
//               o_level  - synchronised level
//               o_rise   - one-cycle pulse on synchronised rising edge
//               o_fall   - one-cycle pulse on synchronised falling edge
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_sync_edge
  import pwm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = c_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================================
// Module      : pwm_capture
// Description : Measures high time and period (rise to rise) of a PWM line in
//               clock cycles and reports each completed period over a
//               valid/ready interface. A constant level for TIMEOUT cycles
//               raises a one-cycle timeout pulse and records the idle level.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               pwm_in                - PWM waveform (asynchronous)
//               meas_valid/meas_ready - result handshake
//               high_cnt, period_cnt  - reported measurement
//               overrun               - result overwrote an unconsumed one
//               timeout, idle_level   - no-edge pulse and level at timeout
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = c_WIDTH,
  parameter int unsigned SYNC_STAGES = c_SYNC_STAGES,
  parameter int unsigned TIMEOUT     = c_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [WIDTH-1:0] high_cnt,
  output logic [WIDTH-1:0] period_cnt,
  output logic             overrun,
  output logic             timeout,
  output logic             idle_level
);

  localparam logic [WIDTH-1:0] c_TIMEOUT_W = WIDTH'(TIMEOUT);

  logic w_level;
  logic w_rise;
  logic w_fall;

  pwm_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .i_async (pwm_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  pwm_state_e       r_state;
  pwm_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_run_cnt;
  logic [WIDTH-1:0] r_high_lat;
  logic [WIDTH-1:0] r_high_cnt;
  logic [WIDTH-1:0] r_period_cnt;
  logic             r_meas_valid;
  logic             r_overrun;
  logic             r_timeout;
  logic             r_idle_level;

  logic w_to_hit;
  logic w_latch_high;
  logic w_publish;
  logic w_timeout;

  // Timeout has priority over an edge landing on the same cycle, which keeps
  // run_cnt bounded by TIMEOUT while a measurement is in progress.
  assign w_to_hit = (r_run_cnt >= c_TIMEOUT_W);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ARM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARM: begin
        if (w_rise) w_state_nxt = ST_HIGH;
      end
      ST_HIGH: begin
        if (w_to_hit)     w_state_nxt = ST_ARM;
        else if (w_fall)  w_state_nxt = ST_LOW;
      end
      ST_LOW: begin
        if (w_to_hit)     w_state_nxt = ST_ARM;
        else if (w_rise)  w_state_nxt = ST_HIGH;
      end
      default: w_state_nxt = ST_ARM;
    endcase
  end

  // Output decode
  always_comb begin
    w_latch_high = 1'b0;
    w_publish    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_HIGH: begin
        w_timeout    = w_to_hit;
        w_latch_high = ~w_to_hit & w_fall;
      end
      ST_LOW: begin
        w_timeout = w_to_hit;
        w_publish = ~w_to_hit & w_rise;
      end
      default: ;
    endcase
  end

  // Run counter restarts at 1 on every rise and idles while armed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_cnt <= '0;
    end else if (w_rise) begin
      r_run_cnt <= WIDTH'(1);
    end else if (r_state != ST_ARM) begin
      r_run_cnt <= r_run_cnt + WIDTH'(1);
    end
  end

  // Result registers and handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_high_lat   <= '0;
      r_high_cnt   <= '0;
      r_period_cnt <= '0;
      r_meas_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
      r_idle_level <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if (w_timeout) r_idle_level <= w_level;
      if (w_latch_high) r_high_lat <= r_run_cnt;

      if (w_publish) begin
        r_high_cnt   <= r_high_lat;
        r_period_cnt <= r_run_cnt;
        r_meas_valid <= 1'b1;
        // Only an unconsumed result being replaced counts as an overrun;
        // a publish coincident with an accept is clean.
        r_overrun    <= r_meas_valid & ~meas_ready;
      end else if (r_meas_valid && meas_ready) begin
        r_meas_valid <= 1'b0;
      end
    end
  end

  assign meas_valid = r_meas_valid;
  assign high_cnt   = r_high_cnt;
  assign period_cnt = r_period_cnt;
  assign overrun    = r_overrun;
  assign timeout    = r_timeout;
  assign idle_level = r_idle_level;

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
// Module      : tb_pwm_capture
// Description : Directed self-checking bench for pwm_capture with a short
//               timeout. Inputs change 1 time unit after the rising clock
//               edge and outputs are checked at the same point.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pwm_capture;

  localparam int unsigned WIDTH       = 16;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned TIMEOUT     = 32;

  logic             clk;
  logic             reset;
  logic             pwm_in;
  logic             meas_valid;
  logic             meas_ready;
  logic [WIDTH-1:0] high_cnt;
  logic [WIDTH-1:0] period_cnt;
  logic             overrun;
  logic             timeout;
  logic             idle_level;

  int n_vec;
  int n_err;

  pwm_capture #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .overrun    (overrun),
    .timeout    (timeout),
    .idle_level (idle_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) tick();
  endtask

  task automatic do_reset(input logic lvl);
    reset  = 1'b1;
    pwm_in = lvl;
    repeat (3) tick();
    reset  = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input int hi, input int per, input logic ov);
    check({tag, ".valid"},   32'(meas_valid), 32'd1);
    check({tag, ".high"},    32'(high_cnt),   32'(hi));
    check({tag, ".period"},  32'(period_cnt), 32'(per));
    check({tag, ".overrun"}, 32'(overrun),    32'(ov));
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    pwm_in     = 1'b0;
    meas_ready = 1'b0;

    // ---- Test 1: 5 high / 1 low, ready held high ----
    meas_ready = 1'b1;
    do_reset(1'b0);
    check("rst.valid",   32'(meas_valid), 32'd0);
    check("rst.high",    32'(high_cnt),   32'd0);
    check("rst.period",  32'(period_cnt), 32'd0);
    check("rst.overrun", 32'(overrun),    32'd0);
    check("rst.timeout", 32'(timeout),    32'd0);
    check("rst.idle",    32'(idle_level), 32'd0);
    drive(1'b0, 3);
    drive(1'b1, 5);
    drive(1'b0, 1);
    drive(1'b1, 2);
    check("t1.latency2", 32'(meas_valid), 32'd0);
    tick();
    check_result("t1.first", 5, 6, 1'b0);
    tick();
    check("t1.accept", 32'(meas_valid), 32'd0);
    drive(1'b1, 1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1);
      drive(1'b1, 5);
    end
    check("t1.steady.valid",  32'(meas_valid), 32'd0);
    check("t1.steady.high",   32'(high_cnt),   32'd5);
    check("t1.steady.period", 32'(period_cnt), 32'd6);
    check("t1.steady.ovr",    32'(overrun),    32'd0);

    // ---- Test 2: timeout while low, then while high ----
    meas_ready = 1'b0;
    do_reset(1'b0);
    drive(1'b0, 3);
    drive(1'b1, 5);
    drive(1'b0, 1);
    drive(1'b1, 5);
    check_result("t2.pending", 5, 6, 1'b0);
    drive(1'b0, 29);
    check("t2.lo.before", 32'(timeout), 32'd0);
    tick();
    check("t2.lo.pulse", 32'(timeout),    32'd1);
    check("t2.lo.idle",  32'(idle_level), 32'd0);
    check_result("t2.lo.held", 5, 6, 1'b0);
    tick();
    check("t2.lo.after", 32'(timeout), 32'd0);
    drive(1'b1, 34);
    check("t2.hi.before", 32'(timeout), 32'd0);
    tick();
    check("t2.hi.pulse", 32'(timeout),    32'd1);
    check("t2.hi.idle",  32'(idle_level), 32'd1);
    check_result("t2.hi.held", 5, 6, 1'b0);
    tick();
    check("t2.hi.after", 32'(timeout), 32'd0);
    drive(1'b1, 14);
    check("t2.hi.single", 32'(timeout), 32'd0);

    // ---- Test 5: reset mid high phase ----
    drive(1'b0, 3);
    drive(1'b1, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5.valid",   32'(meas_valid), 32'd0);
    check("t5.high",    32'(high_cnt),   32'd0);
    check("t5.period",  32'(period_cnt), 32'd0);
    check("t5.overrun", 32'(overrun),    32'd0);
    check("t5.timeout", 32'(timeout),    32'd0);
    check("t5.idle",    32'(idle_level), 32'd0);
    drive(1'b1, 1);
    drive(1'b0, 2);
    drive(1'b1, 5);
    drive(1'b0, 1);
    drive(1'b1, 2);
    check("t5.nopartial", 32'(meas_valid), 32'd0);
    tick();
    check_result("t5.result", 5, 6, 1'b0);

    // ---- Test 3: 3 high / 7 low, ready low for three publishes ----
    do_reset(1'b0);
    drive(1'b0, 3);
    drive(1'b1, 3);
    drive(1'b0, 7);
    drive(1'b1, 3);
    check_result("t3.pub1", 3, 10, 1'b0);
    drive(1'b0, 7);
    drive(1'b1, 3);
    check_result("t3.pub2", 3, 10, 1'b1);
    drive(1'b0, 7);
    drive(1'b1, 3);
    check_result("t3.pub3", 3, 10, 1'b1);
    meas_ready = 1'b1;
    tick();
    check("t3.drain", 32'(meas_valid), 32'd0);

    // ---- Test 4: accept coincident with publish ----
    meas_ready = 1'b0;
    do_reset(1'b0);
    drive(1'b0, 3);
    drive(1'b1, 3);
    drive(1'b0, 7);
    drive(1'b1, 3);
    drive(1'b0, 7);
    drive(1'b1, 5);
    drive(1'b0, 3);
    check_result("t4.overrun", 3, 10, 1'b1);
    drive(1'b1, 2);
    meas_ready = 1'b1;
    tick();
    check_result("t4.coincide", 5, 8, 1'b0);
    tick();
    check("t4.drain", 32'(meas_valid), 32'd0);

    // ---- Test 6: pwm high at reset release ----
    meas_ready = 1'b0;
    do_reset(1'b1);
    drive(1'b1, 2);
    drive(1'b0, 3);
    drive(1'b1, 5);
    drive(1'b0, 1);
    drive(1'b1, 2);
    check("t6.nopartial", 32'(meas_valid), 32'd0);
    tick();
    check_result("t6.result", 5, 6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
